// File: rtl/two_stream_arbiter.sv
// Two-stream valid/ready arbiter feeding a one-entry output register with source tag.
// Define ARB_RR_EN for round-robin contention; otherwise stream A has fixed priority.
module two_stream_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel
);

  // Handshake: a word moves when valid and ready are both high on a rising edge.
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sel_q, sel_d;
  logic             load_en;
  logic             grant_a, grant_b;
  logic             xfer;

`ifdef ARB_RR_EN
  // last_q records the most recent winner; 1 out of reset so A wins first.
  logic last_q, last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  always_comb begin
    grant_a = a_valid & (~b_valid | last_q);
    grant_b = b_valid & ~grant_a;
    last_d  = xfer ? grant_b : last_q;
  end
`else
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid & ~a_valid;
  end
`endif

  assign load_en = ~valid_q | out_ready;
  // Readies are forced low while reset is held, even though the register reads empty.
  assign a_ready = ~rst & load_en & grant_a;
  assign b_ready = ~rst & load_en & grant_b;
  assign xfer    = a_ready | b_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    if (xfer) begin
      data_d  = grant_b ? b_data : a_data;
      sel_d   = grant_b;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign sel       = sel_q;

endmodule

// File: doc/two_stream_arbiter.md
# two_stream_arbiter

Sequential front end for the 4-bit two-input selection path. It accepts two valid/ready data streams (`a`, `b`), picks one per cycle by round-robin arbitration, and captures the winner in a one-entry output register. It also emits `sel`, the source tag of the registered word (0 = `a`, 1 = `b`), in the same encoding the downstream 2:1 mux stage uses.

## Interface
- `WIDTH`, default 4: data width of both inputs and the output.

- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous reset, active-high.
- `a_data` input WIDTH: stream A payload.
- `a_valid` input 1: stream A word present.
- `a_ready` output 1: stream A word accepted this cycle.
- `b_data` input WIDTH: stream B payload.
- `b_valid` input 1: stream B word present.
- `b_ready` output 1: stream B word accepted this cycle.
- `out_data` output WIDTH: registered selected word.
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: consumer takes the word this cycle.
- `sel` output 1: source of the word currently in `out_data` (0 = A, 1 = B).

One clock; reset is asynchronous and active-high (`clk`, `rst`).

## Operation
- Output register is the only storage. It is EMPTY when `out_valid`=0 and FULL when `out_valid`=1.
- `load_en` = !`out_valid` | `out_ready`. A new word can load when the register is empty or is being drained in the same cycle.
- Grant is combinational from `a_valid`, `b_valid` and `last`:
  - Only one source valid: that source wins.
  - Both valid: the source with `last` != it wins (round-robin).
  - Neither valid: no grant.
- `a_ready` = `load_en` & grant_A. `b_ready` = `load_en` & grant_B.
  - At most one ready is high in any cycle.
  - A ready may depend on either valid.
- On a transfer (x_valid & x_ready):
  - `out_data` <= x_data.
  - `sel` <= source.
  - `out_valid` <= 1.
  - `last` <= source.
- Drain with no load (`out_valid` & `out_ready` and no grant): `out_valid` <= 0. `out_data` and `sel` hold their values.
- FULL and `out_ready`=0: both readies are 0. `out_data` and `sel` hold.
- Producers must hold valid high and data stable until their ready is seen. The block does not check this.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `sel`=0.
  - Internal `last`=1, so A wins the first contention.
  - `a_ready`=`b_ready`=0 while `rst` is high.
- Latency: an input accepted at edge N appears on `out_data`/`out_valid` after edge N.
- Throughput: one word per cycle while `out_ready`=1.
- Simultaneous drain and load: the old word leaves and the new word enters on the same edge. `out_valid` stays 1.
- Reset mid-operation: the held word is discarded immediately (asynchronous). Arbitration restarts with A priority.

## Configuration
- `ARB_RR_EN` defined: round-robin contention resolution as described above.
- `ARB_RR_EN` undefined:
  - Fixed priority: A always wins when both are valid.
  - `last` is not implemented.
  - B is served only in cycles where `a_valid`=0.

## Test plan
- Reset check: assert `rst` mid-stream while FULL. Immediately `out_valid`=0, `out_data`=0, `sel`=0, and both readies are 0.
- Single source: `a_valid`=1, `a_data`=4'h5, `out_ready`=1, B idle. One cycle later `out_data`=4'h5, `sel`=0. Steady state: `a_ready`=1 every cycle.
- Contention with `ARB_RR_EN`: both valid continuously, A = 4'h1, B = 4'hE, `out_ready`=1. Output sequence is 1,E,1,E…, `sel` toggles 0,1,0,1, and A is first.
- Contention without `ARB_RR_EN`: same stimulus gives output 1,1,1…, `sel`=0, and `b_ready` is never 1.
- Backpressure: FULL with 4'h3, `out_ready`=0 for 3 cycles while both inputs are valid. `out_data` stays 4'h3 and both readies are 0. When `out_ready` rises, the next word loads on that edge and `out_valid` stays 1.
- Drain to empty: FULL, `out_ready`=1, no input valid. The next cycle has `out_valid`=0 and `out_data`/`sel` unchanged.
